// File: rtl/gfx_pkg.sv
// Shared graphics types and default screen geometry for the raster pipeline.
package gfx_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 400;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } raster_state_t;

endpackage

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches a two-endpoint command and walks it one pixel per clock,
// presenting each pixel on x_pos/y_pos with en low for off-screen pixels and held cycles.
module line_rasterizer
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic [3:0] color_i,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       en,
  output logic [3:0] color_o
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  raster_state_t      state;
  coord_t             x0_q, y0_q, x1_q, y1_q;
  logic signed [10:0] dx_q, dy_q;
  logic               sx_neg, sy_neg;
  logic signed [11:0] err_q;

  logic               sx_neg_init, sy_neg_init;
  logic        [9:0]  adx, ady;
  logic signed [10:0] dx_init, dy_init;
  logic signed [11:0] err_init;

  logic signed [12:0] e2, dx_ext13, dy_ext13;
  logic signed [11:0] dx_ext12, dy_ext12, err_nxt;
  logic               step_x, step_y, at_end;
  coord_t             x_nxt, y_nxt;

  function automatic logic on_screen(input coord_t x, input coord_t y);
    return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  endfunction

  // Setup terms: dx is the positive x span, dy the negated y span.
  always_comb begin
    sx_neg_init = (x1_q < x0_q);
    sy_neg_init = (y1_q < y0_q);
    adx         = sx_neg_init ? (x0_q - x1_q) : (x1_q - x0_q);
    ady         = sy_neg_init ? (y0_q - y1_q) : (y1_q - y0_q);
    dx_init     = $signed({1'b0, adx});
    dy_init     = -$signed({1'b0, ady});
    err_init    = $signed({dx_init[10], dx_init}) + $signed({dy_init[10], dy_init});
  end

  // Per-pixel step; x and y decisions share one e2 so diagonal moves happen in one cycle.
  always_comb begin
    dx_ext12 = $signed({dx_q[10], dx_q});
    dy_ext12 = $signed({dy_q[10], dy_q});
    dx_ext13 = $signed({{2{dx_q[10]}}, dx_q});
    dy_ext13 = $signed({{2{dy_q[10]}}, dy_q});
    e2       = $signed({err_q, 1'b0});
    step_x   = (e2 >= dy_ext13);
    step_y   = (e2 <= dx_ext13);
    err_nxt  = err_q;
    if (step_x) err_nxt = err_nxt + dy_ext12;
    if (step_y) err_nxt = err_nxt + dx_ext12;
    x_nxt    = x_pos;
    y_nxt    = y_pos;
    if (step_x) x_nxt = sx_neg ? (x_pos - 10'd1) : (x_pos + 10'd1);
    if (step_y) y_nxt = sy_neg ? (y_pos - 10'd1) : (y_pos + 10'd1);
    at_end   = (x_pos == x1_q) && (y_pos == y1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      en      <= 1'b0;
      x_pos   <= '0;
      y_pos   <= '0;
      color_o <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      err_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          en <= 1'b0;
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            color_o <= color_i;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          // The first pixel is the start point itself, issued as DRAW is entered.
          dx_q   <= dx_init;
          dy_q   <= dy_init;
          sx_neg <= sx_neg_init;
          sy_neg <= sy_neg_init;
          err_q  <= err_init;
          x_pos  <= x0_q;
          y_pos  <= y0_q;
          en     <= on_screen(x0_q, y0_q);
          state  <= DRAW;
        end
        DRAW: begin
          if (hold) begin
            en <= 1'b0;
          end else if (at_end) begin
            en    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            err_q <= err_nxt;
            en    <= on_screen(x_nxt, y_nxt);
          end
        end
        DONE: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Bench for line_rasterizer: directed lines with fixed pixel lists plus random lines
// compared cycle-by-cycle against an integer Bresenham reference.
module tb_line_rasterizer;

  logic       clk = 1'b0;
  logic       rst_n, start, hold;
  logic [9:0] x0, y0, x1, y1;
  logic [3:0] color_i;
  logic       busy, done, en;
  logic [9:0] x_pos, y_pos;
  logic [3:0] color_o;

  always #5 clk = ~clk;

  line_rasterizer #(.H_RES(640), .V_RES(400)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_i(color_i),
    .hold(hold), .busy(busy), .done(done),
    .x_pos(x_pos), .y_pos(y_pos), .en(en), .color_o(color_o)
  );

  typedef struct packed {
    logic       en;
    logic       done;
    logic       busy;
    logic       chk_xy;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] col;
  } ob_t;

  localparam int BUDGET = 3000;

  ob_t obs[$];
  ob_t exp_q[$];
  int  pix_x[$];
  int  pix_y[$];
  int  n_assert = 0;
  int  n_fail = 0;
  bit  timed_out;

  // Observation c0 is the cycle after start is accepted; one entry per cycle until one past done.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int acol,
                          input int hold_at, input int hold_len, input bit hold_setup, input bit poke);
    int  done_idx;
    ob_t o;
    done_idx = -1;
    obs.delete();
    timed_out = 1'b0;
    @(negedge clk);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    color_i = 4'(acol); start = 1'b1; hold = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      o.en = en; o.done = done; o.busy = busy; o.chk_xy = 1'b0;
      o.x = x_pos; o.y = y_pos; o.col = color_o;
      obs.push_back(o);
      if (done_idx >= 0) begin
        hold = 1'b0; start = 1'b0;
        return;
      end
      if (done === 1'b1) done_idx = c;
      start = poke && (c == 0 || c == 2);
      if (start) begin
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd1000; y1 = 10'd999; color_i = ~color_i;
      end
      hold = ((c + 1) >= hold_at && (c + 1) < hold_at + hold_len) || (hold_setup && c == 0);
    end
    timed_out = 1'b1;
    hold = 1'b0; start = 1'b0;
  endtask

  function automatic bit vis(input int x, input int y);
    return (x < 640) && (y < 400);
  endfunction

  // Reference: list the line's pixels with integer arithmetic, then lay them out in time.
  task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1, input int acol,
                           input int hold_at, input int hold_len);
    int  px[$], py[$];
    int  dx, dy, sx, sy, err, e2, x, y, shown, c;
    ob_t o;
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int k = 0; k < 2100; k++) begin
      px.push_back(x); py.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    exp_q.delete();
    o = '0; o.busy = 1'b1; o.col = 4'(acol);
    exp_q.push_back(o);
    o.en = vis(px[0], py[0]); o.chk_xy = 1'b1; o.x = 10'(px[0]); o.y = 10'(py[0]);
    exp_q.push_back(o);
    shown = 1;
    c = 2;
    forever begin
      o = '0; o.busy = 1'b1; o.col = 4'(acol); o.chk_xy = 1'b1;
      o.x = 10'(px[shown-1]); o.y = 10'(py[shown-1]);
      if (c >= hold_at && c < hold_at + hold_len) begin
        o.en = 1'b0;
      end else if (shown < px.size()) begin
        o.x = 10'(px[shown]); o.y = 10'(py[shown]); o.en = vis(px[shown], py[shown]);
        shown++;
      end else begin
        o.done = 1'b1;
        exp_q.push_back(o);
        o.done = 1'b0; o.busy = 1'b0;
        exp_q.push_back(o);
        break;
      end
      exp_q.push_back(o);
      c++;
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs[i].en !== exp_q[i].en || obs[i].done !== exp_q[i].done ||
          obs[i].busy !== exp_q[i].busy || obs[i].col !== exp_q[i].col) return i;
      if (exp_q[i].chk_xy && (obs[i].x !== exp_q[i].x || obs[i].y !== exp_q[i].y)) return i;
    end
    return (obs.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic int done_index();
    for (int i = 0; i < obs.size(); i++) if (obs[i].done === 1'b1) return i;
    return -1;
  endfunction

  function automatic void get_pixels();
    pix_x.delete(); pix_y.delete();
    for (int i = 0; i < obs.size(); i++)
      if (obs[i].en === 1'b1) begin pix_x.push_back(int'(obs[i].x)); pix_y.push_back(int'(obs[i].y)); end
  endfunction

  task automatic report_trace(input string name, input int d);
    ob_t g, w;
    g = '0; w = '0;
    if (d < obs.size()) g = obs[d];
    if (d < exp_q.size()) w = exp_q[d];
    $display("FAIL %s: cycle %0d got en=%0b done=%0b busy=%0b x=%0d y=%0d col=%0d, want en=%0b done=%0b busy=%0b x=%0d y=%0d col=%0d (len %0d vs %0d, timeout=%0b)",
             name, d, g.en, g.done, g.busy, g.x, g.y, g.col, w.en, w.done, w.busy, w.x, w.y, w.col,
             obs.size(), exp_q.size(), timed_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; hold = 1'b0;
    x0 = 10'd7; y0 = 10'd7; x1 = 10'd9; y1 = 10'd9; color_i = 4'hf;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, en, x_pos, y_pos, color_o} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b en=%b x=%0d y=%0d col=%0d, want all 0",
               busy, done, en, x_pos, y_pos, color_o);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_horizontal();
    int d, di;
    int wx[4] = '{0, 1, 2, 3};
    run_line(0, 0, 3, 0, 5, 0, 0, 1'b0, 1'b0);
    build_exp(0, 0, 3, 0, 5, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("horiz_trace", d); end
    get_pixels();
    n_assert++;
    if (pix_x.size() != 4) begin n_fail++; $display("FAIL horiz_count: got %0d pixels, want 4", pix_x.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (pix_x[i] != wx[i] || pix_y[i] != 0 || obs[i+1].en !== 1'b1 || obs[i+1].col !== 4'd5) begin
        n_fail++;
        $display("FAIL horiz_pixel%0d: got (%0d,%0d) en=%b col=%0d, want (%0d,0) en=1 col=5",
                 i, pix_x[i], pix_y[i], obs[i+1].en, obs[i+1].col, wx[i]);
      end
    end
    di = done_index();
    n_assert++;
    if (di != 5) begin n_fail++; $display("FAIL horiz_done_cycle: got N+%0d, want N+6", di + 1); end
  endtask

  task automatic test_steep();
    int d;
    int wx[5] = '{5, 5, 6, 6, 6};
    int wy[5] = '{0, 1, 2, 3, 4};
    run_line(5, 0, 6, 4, 2, 0, 0, 1'b0, 1'b0);
    build_exp(5, 0, 6, 4, 2, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("steep_trace", d); end
    get_pixels();
    n_assert++;
    if (pix_x.size() != 5) begin n_fail++; $display("FAIL steep_count: got %0d pixels, want 5", pix_x.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_assert++;
      if (pix_x[i] != wx[i] || pix_y[i] != wy[i]) begin
        n_fail++;
        $display("FAIL steep_pixel%0d: got (%0d,%0d), want (%0d,%0d)", i, pix_x[i], pix_y[i], wx[i], wy[i]);
      end
    end
  endtask

  task automatic test_reverse_diag();
    int d;
    int wx[4] = '{10, 9, 8, 7};
    int wy[4] = '{10, 11, 12, 13};
    run_line(10, 10, 7, 13, 12, 0, 0, 1'b0, 1'b0);
    build_exp(10, 10, 7, 13, 12, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("rdiag_trace", d); end
    get_pixels();
    n_assert++;
    if (pix_x.size() != 4) begin n_fail++; $display("FAIL rdiag_count: got %0d pixels, want 4", pix_x.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (pix_x[i] != wx[i] || pix_y[i] != wy[i]) begin
        n_fail++;
        $display("FAIL rdiag_pixel%0d: got (%0d,%0d), want (%0d,%0d)", i, pix_x[i], pix_y[i], wx[i], wy[i]);
      end
    end
  endtask

  task automatic test_point();
    int d, di;
    run_line(20, 30, 20, 30, 1, 0, 0, 1'b0, 1'b0);
    build_exp(20, 30, 20, 30, 1, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("point_trace", d); end
    get_pixels();
    di = done_index();
    n_assert++;
    if (pix_x.size() != 1 || di != 2 || pix_x[0] != 20 || pix_y[0] != 30) begin
      n_fail++;
      $display("FAIL point_single: got %0d pixels, done at c%0d, want 1 pixel (20,30) done at c2", pix_x.size(), di);
    end
  endtask

  task automatic test_clipping();
    int d, di;
    run_line(638, 399, 641, 399, 9, 0, 0, 1'b0, 1'b0);
    build_exp(638, 399, 641, 399, 9, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("clip_trace", d); end
    get_pixels();
    di = done_index();
    n_assert++;
    if (pix_x.size() != 2 || di != 5 || pix_x[0] != 638 || pix_x[1] != 639) begin
      n_fail++;
      $display("FAIL clip_visible: got %0d en pixels, done at c%0d, want 2 (638,639) done at c5", pix_x.size(), di);
    end
  endtask

  task automatic test_start_ignored();
    int d;
    run_line(100, 50, 110, 57, 3, 0, 0, 1'b0, 1'b1);
    build_exp(100, 50, 110, 57, 3, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("start_ignored_trace", d); end
  endtask

  task automatic test_hold();
    int d, di;
    run_line(5, 5, 12, 9, 7, 3, 3, 1'b1, 1'b0);
    build_exp(5, 5, 12, 9, 7, 3, 3);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("hold_trace", d); end
    get_pixels();
    di = done_index();
    n_assert++;
    if (pix_x.size() != 8 || di != 12) begin
      n_fail++;
      $display("FAIL hold_stretch: got %0d pixels, done at c%0d, want 8 pixels done at c12", pix_x.size(), di);
    end
  endtask

  task automatic test_reset_midline();
    int bad;
    @(negedge clk);
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd50; y1 = 10'd20; color_i = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({busy, done, en, x_pos, y_pos, color_o} !== 27'd0) begin
      n_fail++;
      $display("FAIL midline_reset: got busy=%b done=%b en=%b x=%0d y=%0d col=%0d, want all 0",
               busy, done, en, x_pos, y_pos, color_o);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL midline_no_done: got %0d active cycles after reset, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int d;
    run_line(3, 8, 0, 0, 4, 0, 0, 1'b0, 1'b0);
    build_exp(3, 8, 0, 0, 4, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("b2b_first", d); end
    run_line(0, 399, 9, 395, 11, 0, 0, 1'b0, 1'b0);
    build_exp(0, 399, 9, 395, 11, 0, 0);
    n_assert++; d = first_diff();
    if (d != -1) begin n_fail++; report_trace("b2b_second", d); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int ax0, ay0, ax1, ay1, col, ha, hl, d, di, holds, span;
      bit hs, pk;
      if (t % 2 == 0) begin
        ax0 = $urandom_range(0, 1023); ay0 = $urandom_range(0, 1023);
        ax1 = $urandom_range(0, 1023); ay1 = $urandom_range(0, 1023);
      end else begin
        ax0 = $urandom_range(620, 660); ay0 = $urandom_range(380, 420);
        ax1 = $urandom_range(620, 660); ay1 = $urandom_range(380, 420);
      end
      col = $urandom_range(0, 15);
      ha  = $urandom_range(2, 8);
      hl  = $urandom_range(0, 4);
      hs  = 1'($urandom_range(0, 1));
      pk  = 1'($urandom_range(0, 1));
      run_line(ax0, ay0, ax1, ay1, col, ha, hl, hs, pk);
      build_exp(ax0, ay0, ax1, ay1, col, ha, hl);
      n_assert++; d = first_diff();
      if (d != -1) begin n_fail++; report_trace("random_trace", d); end
      di = done_index();
      holds = 0;
      for (int c = 2; c < di; c++) if (c >= ha && c < ha + hl) holds++;
      span = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      if (((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1) > span) span = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
      n_assert++;
      if (di - 1 - holds != span + 1) begin
        n_fail++;
        $display("FAIL random_count: line (%0d,%0d)->(%0d,%0d) got %0d pixel cycles, want %0d",
                 ax0, ay0, ax1, ay1, di - 1 - holds, span + 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_i = '0;
    test_reset();
    test_horizontal();
    test_steep();
    test_reverse_diag();
    test_point();
    test_clipping();
    test_start_ignored();
    test_hold();
    test_reset_midline();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
